// File: rtl/alu_seq_ctrl_if.sv
// Requester/response bundle for alu_seq_ctrl.
// master: requester fabric side; slave: controller side.
interface alu_seq_ctrl_if #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]    req_cin;
  logic [NREQ*4-1:0]  req_sel;
  logic [NREQ*5-1:0]  req_shamt;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_f;
  logic               rsp_cout;

  modport master (
    output req_valid, req_a, req_b, req_cin, req_sel, req_shamt, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_f, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_sel, req_shamt, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_f, rsp_cout
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: round-robin front end sharing one combinational ALU among
// NREQ requesters, one operation in flight. Shift ops (sel[3]=1) are
// iterated through the ALU's 1-bit shift shamt times.
// Optional feature macro: ALU_SEQ_ZERO_FLAG_EN adds a registered rsp_zero
// flag (final result == 0).
//
// state | meaning
// IDLE  | arbitrate; grant accepted request, latch payload
// EXEC  | drive ALU from latched operands; one cycle per op or per shift bit
// RESP  | hold response until rsp_ready
module alu_seq_ctrl #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic        clk,
  input  logic        rst,
  alu_seq_ctrl_if.slave bus,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_cin,
  output logic [3:0]  alu_sel,
  input  logic [31:0] alu_f,
  input  logic        alu_cout,
  output logic        busy
`ifdef ALU_SEQ_ZERO_FLAG_EN
  ,
  output logic        rsp_zero
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [31:0]    a_q;
  logic [31:0]    b_q;
  logic           cin_q;
  logic [3:0]     sel_q;
  logic [4:0]     cnt_q;
  logic [IDW-1:0] id_q;
  logic [31:0]    f_q;
  logic           cout_q;

  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic [IDW:0]   cand;
  logic [IDW-1:0] rr_nxt;
  logic [31:0]    g_a;
  logic [31:0]    g_b;
  logic           g_cin;
  logic [3:0]     g_sel;
  logic [4:0]     g_shamt;
  logic           g_shift0;

  // Round-robin search starting at rr_ptr, wrapping modulo NREQ.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!gnt_any && bus.req_valid[cand[IDW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[IDW-1:0];
      end
    end
  end

  assign rr_nxt   = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
  assign g_a      = bus.req_a[32*gnt_idx +: 32];
  assign g_b      = bus.req_b[32*gnt_idx +: 32];
  assign g_cin    = bus.req_cin[gnt_idx];
  assign g_sel    = bus.req_sel[4*gnt_idx +: 4];
  assign g_shamt  = bus.req_shamt[5*gnt_idx +: 5];
  // A zero-length shift never touches the ALU; result is operand A.
  assign g_shift0 = g_sel[3] && (g_shamt == 5'd0);

  // Ready only toward the granted requester while idle.
  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && gnt_any) bus.req_ready[gnt_idx] = 1'b1;
  end

  // Main sequencer: accept, execute/iterate, respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cin_q  <= 1'b0;
      sel_q  <= '0;
      cnt_q  <= '0;
      id_q   <= '0;
      f_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            a_q    <= g_a;
            b_q    <= g_b;
            cin_q  <= g_cin;
            sel_q  <= g_sel;
            cnt_q  <= g_shamt;
            id_q   <= gnt_idx;
            rr_ptr <= rr_nxt;
            if (g_shift0) begin
              f_q    <= g_a;
              cout_q <= 1'b0;
              state  <= RESP;
            end else begin
              state  <= EXEC;
            end
          end
        end
        EXEC: begin
          f_q    <= alu_f;
          cout_q <= alu_cout;
          if (sel_q[3]) begin
            a_q   <= alu_f;
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == 5'd1) state <= RESP;
          end else begin
            state <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic zero_q;

  // Zero flag tracks whatever value is being written into f_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else if (state == IDLE && gnt_any && g_shift0) begin
      zero_q <= (g_a == 32'd0);
    end else if (state == EXEC) begin
      zero_q <= (alu_f == 32'd0);
    end
  end

  assign rsp_zero = zero_q;
`endif

  assign alu_a         = (state == EXEC) ? a_q   : '0;
  assign alu_b         = (state == EXEC) ? b_q   : '0;
  assign alu_cin       = (state == EXEC) ? cin_q : 1'b0;
  assign alu_sel       = (state == EXEC) ? sel_q : '0;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_f     = f_q;
  assign bus.rsp_cout  = cout_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a small behavioural ALU attached.
// ALU model: 0001 add a+b+cin; 10?? shift right by 1 (cin in, a[0] out);
// 11?? shift left by 1 (cin in, a[31] out); anything else a&b.
module tb_alu_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_cin;
  logic [3:0]  alu_sel;
  logic [31:0] alu_f;
  logic        alu_cout;
  logic        busy;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic        rsp_zero;
`endif

  int errors = 0;
  int checks = 0;

  alu_seq_ctrl_if #(.NREQ(2), .IDW(1)) bus ();

  alu_seq_ctrl #(.NREQ(2), .IDW(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_cin  (alu_cin),
    .alu_sel  (alu_sel),
    .alu_f    (alu_f),
    .alu_cout (alu_cout),
    .busy     (busy)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    .rsp_zero (rsp_zero)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ALU.
  always_comb begin
    alu_f    = 32'd0;
    alu_cout = 1'b0;
    if (alu_sel == 4'b0001) begin
      {alu_cout, alu_f} = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
    end else if (alu_sel[3:2] == 2'b10) begin
      alu_f    = {alu_cin, alu_a[31:1]};
      alu_cout = alu_a[0];
    end else if (alu_sel[3:2] == 2'b11) begin
      alu_f    = {alu_a[30:0], alu_cin};
      alu_cout = alu_a[31];
    end else begin
      alu_f = alu_a & alu_b;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op from requester idx while idle, optionally backpressure the
  // response for bp cycles (other requester valid meanwhile), then retire it.
  task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic [3:0] sel, input logic [4:0] sh,
                        input int bp, input int exp_lat, input logic [31:0] exp_f,
                        input logic exp_cout);
    int n;
    int oth;
    oth = 1 - idx;
    @(negedge clk);
    bus.req_a[32*idx +: 32]    = a;
    bus.req_b[32*idx +: 32]    = b;
    bus.req_cin[idx]           = cin;
    bus.req_sel[4*idx +: 4]    = sel;
    bus.req_shamt[5*idx +: 5]  = sh;
    bus.req_valid[idx]         = 1'b1;
    #1;
    chk("grant", 32'(bus.req_ready), 32'(1 << idx));
    @(negedge clk);
    bus.req_valid[idx] = 1'b0;
    n = 1;
    while (bus.rsp_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(exp_lat));
    chk("rsp_id", 32'(bus.rsp_id), 32'(idx));
    chk("rsp_f", bus.rsp_f, exp_f);
    chk("rsp_cout", 32'(bus.rsp_cout), 32'(exp_cout));
    chk("alu_sel_resp", 32'(alu_sel), 32'd0);
    chk("alu_a_resp", alu_a, 32'd0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk("rsp_zero", 32'(rsp_zero), 32'(exp_f == 32'd0));
`endif
    for (int i = 0; i < bp; i++) begin
      bus.req_valid[oth] = 1'b1;
      #1;
      chk("bp_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_f", bus.rsp_f, exp_f);
      chk("bp_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    bus.req_valid[oth] = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_valid", 32'(bus.rsp_valid), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int n;
    int m;
    int hits;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.req_sel   = '0;
    bus.req_shamt = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("rst_rsp_f", bus.rsp_f, 32'd0);
    rst = 1'b0;

    // Simultaneous requests: grants alternate 0,1,0,1
    @(negedge clk);
    bus.req_a     = {32'd10, 32'd5};
    bus.req_b     = {32'd20, 32'd3};
    bus.req_sel   = {4'b0001, 4'b0001};
    bus.req_cin   = 2'b00;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (bus.req_ready == 2'b00 && n < 10) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("rr_grant", 32'(bus.req_ready), (k % 2) ? 32'd2 : 32'd1);
      m = 0;
      do begin
        @(negedge clk);
        #1;
        m++;
      end while (bus.rsp_valid !== 1'b1 && m < 10);
      chk("rr_lat", 32'(m), 32'd2);
      chk("rr_id", 32'(bus.rsp_id), 32'(k % 2));
      chk("rr_f", bus.rsp_f, (k % 2) ? 32'd30 : 32'd8);
      if (k == 3) bus.req_valid = 2'b00;
      @(negedge clk);
      #1;
    end
    bus.rsp_ready = 1'b0;

    // Add with carry out
    run_op(0, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'b0001, 5'd0, 0, 2, 32'h0000_0000, 1'b1);
    // Left shift by 4
    run_op(1, 32'h8000_0001, 32'd0, 1'b0, 4'b1100, 5'd4, 0, 5, 32'h0000_0010, 1'b0);
    // Right shift by 0
    run_op(0, 32'h1234_5678, 32'd0, 1'b0, 4'b1000, 5'd0, 0, 1, 32'h1234_5678, 1'b0);
    // Right shift by 3: 0xD -> 0x1, last bit out 1
    run_op(0, 32'h0000_000D, 32'd0, 1'b0, 4'b1000, 5'd3, 0, 4, 32'h0000_0001, 1'b1);
    // Backpressure for 5 cycles
    run_op(1, 32'd7, 32'd8, 1'b0, 4'b0001, 5'd0, 5, 2, 32'd15, 1'b0);

    // Reset mid-shift (shamt=20), rr_ptr moves to 1 before reset
    @(negedge clk);
    bus.req_a[31:0]     = 32'hFFFF_FFFF;
    bus.req_sel[3:0]    = 4'b1000;
    bus.req_shamt[4:0]  = 5'd20;
    bus.req_valid       = 2'b01;
    @(negedge clk);
    bus.req_valid = 2'b00;
    repeat (5) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mr_alu_a", alu_a, 32'd0);
    chk("mr_alu_sel", 32'(alu_sel), 32'd0);
    chk("mr_rsp_f", bus.rsp_f, 32'd0);
    rst = 1'b0;
    hits = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) hits++;
    end
    chk("mr_no_rsp", 32'(hits), 32'd0);
    bus.req_valid = 2'b11;
    #1;
    chk("mr_rr_ptr", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 2'b00;
    run_op(0, 32'h11, 32'h22, 1'b0, 4'b0001, 5'd0, 0, 2, 32'h33, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
